// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its paired memory.
package im_loader_pkg;

  localparam int unsigned IM_MEM_BYTES = 64;
  localparam int unsigned IM_ADDR_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Host-side byte stream, control/status and memory byte-write port of the loader.
interface im_loader_if #(
  parameter int unsigned ADDR_W = im_loader_pkg::IM_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] load_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              err_len;

  modport master (
    output start, load_len, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, err_len
  );

  modport slave (
    input  start, load_len, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, err_len
  );

endinterface

// File: rtl/im_loader.sv
// Streams a program into instruction memory from address 0, zero-fills the
// remainder, then releases the CPU from hold.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IM_MEM_BYTES,
  parameter int unsigned ADDR_W    = IM_ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  im_loader_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic              len_over;
  logic [ADDR_W-1:0] len_clip;

  assign len_over       = 32'(bus.load_len) > MEM_BYTES;
  assign len_clip       = len_over ? ADDR_W'(MEM_BYTES) : bus.load_len;
  assign bus.byte_ready = (state == ST_LOAD);

  // Single FSM; write port and status flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      remaining    <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 8'h00;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.cpu_hold <= 1'b1;
      bus.err_len  <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            ptr          <= '0;
            remaining    <= len_clip;
            bus.err_len  <= len_over;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.cpu_hold <= 1'b1;
            state        <= (len_clip != '0) ? ST_LOAD : ST_FILL;
          end
        end
        ST_LOAD: begin
          if (bus.byte_valid && bus.byte_ready) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= bus.byte_in;
            ptr         <= ptr + ADDR_W'(1);
            remaining   <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) state <= ST_FILL;
          end
        end
        ST_FILL: begin
          // A full-length load arrives here with ptr already at the end.
          if (ptr == ADDR_W'(MEM_BYTES)) begin
            state        <= ST_DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.cpu_hold <= 1'b0;
          end else begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= 8'h00;
            ptr         <= ptr + ADDR_W'(1);
            if (ptr == ADDR_W'(MEM_BYTES - 1)) begin
              state        <= ST_DONE;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
              bus.cpu_hold <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
